// File: rtl/dct_pkg.sv
// dct_pkg: shared sizes, index types and address helper for the 8x8 transpose buffer
package dct_pkg;
  localparam int DCT_N = 8;
  localparam int DCT_SAMPLES = DCT_N * DCT_N;
  localparam int IDX_W = $clog2(DCT_N);
  localparam int CNT_W = $clog2(DCT_SAMPLES);
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  // Read j of a block addresses row j[2:0], column j[5:3] of a row-major bank.
  function automatic cnt_t col_major(cnt_t j);
    return {j[IDX_W-1:0], j[CNT_W-1:IDX_W]};
  endfunction
endpackage

// File: rtl/dct_transpose_buffer_if.sv
// dct_transpose_buffer_if: row-side write handshake and column-side read handshake
// slave = buffer side, master = producer/consumer side
interface dct_transpose_buffer_if import dct_pkg::*; #(parameter int n = 16);
  logic in_valid;
  logic in_ready;
  logic [n-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [n-1:0] out_data;
  idx_t out_add;
  logic out_last;
  logic out_block_last;
  modport slave(input in_valid, in_data, out_ready,
                output in_ready, out_valid, out_data, out_add, out_last, out_block_last);
  modport master(output in_valid, in_data, out_ready,
                 input in_ready, out_valid, out_data, out_add, out_last, out_block_last);
endinterface

// File: rtl/dct_buffer_bank.sv
// dct_buffer_bank: 64 x n sample store, one synchronous write port, one async read port
// ports: clk, we_i/waddr_i/wdata_i write, raddr_i -> rdata_o read
module dct_buffer_bank import dct_pkg::*; #(parameter int n = 16) (
  input  logic         clk,
  input  logic         we_i,
  input  cnt_t         waddr_i,
  input  logic [n-1:0] wdata_i,
  input  cnt_t         raddr_i,
  output logic [n-1:0] rdata_o
);
  logic [n-1:0] mem_q [DCT_SAMPLES];
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/dct_transpose_buffer.sv
// dct_transpose_buffer: ping-pong 8x8 transpose, row-major in, column-major registered out
// ports: clk, reset (sync, active high), bus (slave modport: in_* write side, out_* read side)
module dct_transpose_buffer import dct_pkg::*; #(parameter int n = 16) (
  input logic clk,
  input logic reset,
  dct_transpose_buffer_if.slave bus
);
  cnt_t wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [1:0] full_q, full_d;
  logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [n-1:0] data_q, data_d;
  idx_t add_q, add_d;
  logic valid_q, valid_d, last_q, last_d, blast_q, blast_d;
  logic wr_fire, wr_last, rd_last, avail, load;
  logic [n-1:0] rdata [2];
  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_buffer_bank #(.n(n)) u_bank (
      .clk(clk),
      .we_i(wr_fire && wr_sel_q == 1'(b)),
      .waddr_i(wr_cnt_q),
      .wdata_i(bus.in_data),
      .raddr_i(col_major(rd_cnt_q)),
      .rdata_o(rdata[b])
    );
  end
  assign bus.in_ready = !full_q[wr_sel_q] && !reset;
  assign wr_fire = bus.in_valid && bus.in_ready;
  assign wr_last = wr_fire && &wr_cnt_q;
  // Bypass the full flag while the read bank is filling: read j=0 (write 0) is
  // already stored, so the first output can load on the 64th write itself.
  assign avail = full_q[rd_sel_q] || (wr_last && wr_sel_q == rd_sel_q);
  assign load = avail && (!valid_q || bus.out_ready);
  // The bank is freed when j=63 moves into the output register, which lets the
  // writer reuse it with no bubble between blocks.
  assign rd_last = load && &rd_cnt_q;
  always_comb begin
    wr_cnt_d = wr_fire ? wr_cnt_q + CNT_W'(1) : wr_cnt_q;
    rd_cnt_d = load ? rd_cnt_q + CNT_W'(1) : rd_cnt_q;
    wr_sel_d = wr_sel_q ^ wr_last;
    rd_sel_d = rd_sel_q ^ rd_last;
    full_d = (full_q | (2'(wr_last) << wr_sel_q)) & ~(2'(rd_last) << rd_sel_q);
    valid_d = load || (valid_q && !bus.out_ready);
    data_d = load ? rdata[rd_sel_q] : data_q;
    add_d = load ? rd_cnt_q[IDX_W-1:0] : add_q;
    last_d = load ? &rd_cnt_q[IDX_W-1:0] : last_q;
    blast_d = load ? &rd_cnt_q : blast_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      full_q <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      add_q <= '0;
      last_q <= 1'b0;
      blast_q <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      full_q <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      valid_q <= valid_d;
      data_q <= data_d;
      add_q <= add_d;
      last_q <= last_d;
      blast_q <= blast_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
  assign bus.out_add = add_q;
  assign bus.out_last = last_q;
  assign bus.out_block_last = blast_q;
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// tb_dct_transpose_buffer: scoreboard bench for the 8x8 transpose buffer
module tb_dct_transpose_buffer;
  import dct_pkg::*;
  localparam int N = 16;
  typedef struct packed {logic [N-1:0] d; logic [2:0] a; logic l; logic bl;} out_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  dct_transpose_buffer_if #(.n(N)) bus();
  dct_transpose_buffer #(.n(N)) dut(.clk(clk), .reset(reset), .bus(bus));
  out_t exp_q[$];
  logic [N-1:0] blk[$];
  int compared = 0, mismatched = 0;
  int cyc = 0, accepts = 0, outs = 0, first_out = -1, last_out = -1, in_stall = 0;
  int mode = 0;
  bit prev_stall = 0, lat_pend = 0;
  out_t prev, cur, e;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  // out_ready pattern: 0 always high, 1 always low, 2 toggling, 3 random
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : mode == 2 ? ~bus.out_ready : 1'($urandom_range(0, 1));
    end
  end
  // Monitor: model accepted writes as 8x8 blocks, emit column-major expectations.
  always @(negedge clk) begin
    cyc++;
    cur = '{bus.out_data, bus.out_add, bus.out_last, bus.out_block_last};
    if (reset) begin
      blk.delete();
      exp_q.delete();
      prev_stall = 0;
      lat_pend = 0;
    end else begin
      if (lat_pend) begin
        check("first_valid_latency", 64'(bus.out_valid), 64'(1));
        lat_pend = 0;
      end
      if (prev_stall) check("stall_hold", {bus.out_valid, cur}, {1'b1, prev});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 64'(cur), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("out_sample", 64'(cur), 64'(e));
        end
        outs++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev = cur;
      if (bus.in_valid && !bus.in_ready) in_stall++;
      if (bus.in_valid && bus.in_ready) begin
        accepts++;
        blk.push_back(bus.in_data);
        if (blk.size() == 64) begin
          if (exp_q.size() == 0) lat_pend = 1;
          for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
              exp_q.push_back('{blk[r*8+c], 3'(r), r == 7, r == 7 && c == 7});
          blk.delete();
        end
      end
    end
  end
  task automatic put(input logic [N-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    check("put_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_left", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask
  int acc0, outs0;
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_out_add", 64'(bus.out_add), 64'(0));
    check("rst_out_last", 64'(bus.out_last), 64'(0));
    check("rst_out_block_last", 64'(bus.out_block_last), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    // ramp block, downstream always ready
    mode = 0;
    for (int k = 0; k < 64; k++) put(N'(k));
    drain();
    // two blocks with downstream stalled, then overflow attempts
    mode = 1;
    acc0 = accepts;
    for (int k = 0; k < 128; k++) put(N'($urandom));
    @(negedge clk);
    check("in_ready_both_full", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data = N'($urandom);
    repeat (10) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("accepts_when_full", 64'(accepts - acc0), 64'(128));
    mode = 0;
    drain();
    // toggling out_ready
    mode = 2;
    for (int k = 0; k < 128; k++) put(N'($urandom));
    drain();
    // partial block discarded by reset
    mode = 0;
    for (int k = 0; k < 37; k++) put(N'($urandom));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 100; k < 164; k++) put(N'(k));
    drain();
    // three blocks streaming at full rate
    in_stall = 0;
    first_out = -1;
    outs0 = outs;
    for (int k = 0; k < 192; k++) put(N'($urandom));
    drain();
    check("stream_in_stalls", 64'(in_stall), 64'(0));
    check("stream_out_count", 64'(outs - outs0), 64'(192));
    check("stream_out_span", 64'(last_out - first_out), 64'(191));
    // random out_ready and random input gaps
    mode = 3;
    for (int k = 0; k < 192; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      put(N'($urandom));
    end
    mode = 0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
